// File: rtl/weight_pkg.sv
// Shared FSM state type and latency constants for the weight feeder.
package weight_pkg;

  typedef enum logic [1:0] {IDLE, INIT, READ, DRAIN} state_t;

  localparam int ROM_RD_LAT = 1;

  // Cycles from a READ address to its word on column c.
  function automatic int SKEW_LAT(input int c);
    return c + 2;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed-length register line on {valid, data}; DEPTH = 0 collapses to a wire.
module skew_delay #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_in,
  input  logic [DW-1:0] data_in,
  output logic          vld_out,
  output logic [DW-1:0] data_out
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign vld_out  = vld_in;
    assign data_out = data_in;
  end else begin : g_line
    logic [DEPTH-1:0] vld_q;
    logic [DW-1:0]    data_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        vld_q[0]  <= vld_in;
        data_q[0] <= data_in;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i]  <= vld_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign vld_out  = vld_q[DEPTH-1];
    assign data_out = data_q[DEPTH-1];
  end

endmodule

// File: rtl/weight_feeder.sv
// Drives the per-column weight ROMs and feeds their words, diagonally skewed,
// into the systolic array's weight inputs.
module weight_feeder
  import weight_pkg::*;
#(
  parameter int DW             = 8,
  parameter int COLS           = 8,
  parameter int ADDR_DW        = 5,
  parameter int KERNEL_ELEMENT = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_DW-1:0]   base_addr,
  input  logic [COLS*DW-1:0]   rom_dout,
  output logic                 initial_sig,
  output logic                 RAenable,
  output logic [ADDR_DW-1:0]   addr,
  output logic [COLS*DW-1:0]   w_out,
  output logic [COLS-1:0]      w_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int KW  = $clog2(KERNEL_ELEMENT + 1);
  localparam int DCW = $clog2(COLS + 2);
  localparam logic [KW-1:0]  K_LAST = KW'(KERNEL_ELEMENT - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(COLS);
  localparam logic [DCW-1:0] D_PRE  = DCW'(COLS - 1);

  state_t             state;
  logic               inited;
  logic [KW-1:0]      k;
  logic [DCW-1:0]     dcnt;
  logic [ADDR_DW-1:0] base_q;

  // All control outputs are registered and describe the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      inited      <= 1'b0;
      k           <= '0;
      dcnt        <= '0;
      base_q      <= '0;
      initial_sig <= 1'b0;
      RAenable    <= 1'b0;
      addr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      initial_sig <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            busy   <= 1'b1;
            k      <= '0;
            if (!inited) begin
              state       <= INIT;
              initial_sig <= 1'b1;
            end else begin
              state    <= READ;
              RAenable <= 1'b1;
              addr     <= base_addr;
            end
          end
        end
        INIT: begin
          inited   <= 1'b1;
          state    <= READ;
          RAenable <= 1'b1;
          addr     <= base_q;
        end
        READ: begin
          if (k == K_LAST) begin
            state    <= DRAIN;
            RAenable <= 1'b0;
            addr     <= '0;
            dcnt     <= '0;
          end else begin
            k    <= k + KW'(1);
            addr <= addr + ADDR_DW'(1);
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            dcnt <= dcnt + DCW'(1);
            done <= (dcnt == D_PRE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic               rd_vld;
  logic               cap_vld;
  logic [COLS*DW-1:0] cap;

  // Align the read enable with ROM data, then capture; idle cycles capture zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      cap_vld <= 1'b0;
      cap     <= '0;
    end else begin
      rd_vld  <= RAenable;
      cap_vld <= rd_vld;
      cap     <= rd_vld ? rom_dout : '0;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    skew_delay #(
      .DW   (DW),
      .DEPTH(SKEW_LAT(c) - ROM_RD_LAT - 1)
    ) u_skew (
      .clk     (clk),
      .rst     (rst),
      .vld_in  (cap_vld),
      .data_in (cap[c*DW +: DW]),
      .vld_out (w_valid[c]),
      .data_out(w_out[c*DW +: DW])
    );
  end

endmodule

// File: tb/tb_weight_feeder.sv
// Scoreboard bench for weight_feeder: driver queues timed expectations, a
// negedge monitor pops and compares them against modelled ROM contents.
module tb_weight_feeder;

  localparam int DW      = 8;
  localparam int COLS    = 8;
  localparam int ADDR_DW = 5;
  localparam int KE      = 25;
  localparam int DEPTH   = 1 << ADDR_DW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [ADDR_DW-1:0]   base_addr = '0;
  logic [COLS*DW-1:0]   rom_dout;
  logic                 initial_sig;
  logic                 RAenable;
  logic [ADDR_DW-1:0]   addr;
  logic [COLS*DW-1:0]   w_out;
  logic [COLS-1:0]      w_valid;
  logic                 busy;
  logic                 done;

  weight_feeder #(
    .DW(DW), .COLS(COLS), .ADDR_DW(ADDR_DW), .KERNEL_ELEMENT(KE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .rom_dout(rom_dout), .initial_sig(initial_sig), .RAenable(RAenable),
    .addr(addr), .w_out(w_out), .w_valid(w_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: one-cycle read latency, zero output when not enabled.
  logic [DW-1:0]      rom [COLS][DEPTH];
  logic [COLS*DW-1:0] rom_q = '0;
  assign rom_dout = rom_q;
  always @(posedge clk) begin
    for (int c = 0; c < COLS; c++)
      rom_q[c*DW +: DW] <= RAenable ? rom[c][addr] : '0;
  end

  typedef struct {
    int cyc;
    int val;
    int col;
  } exp_t;

  exp_t addr_q[$];
  exp_t col_q[$];
  int   init_q[$];
  int   done_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;
  bit inited_m = 1'b0;
  int busy_from = 1;
  int busy_to = 0;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Queue every observable consequence of an accepted start from the kernel rules.
  task automatic apply_stimulus(input logic [ADDR_DW-1:0] b, output int s, output int dc);
    int rs;
    s = cyc;
    start = 1'b1;
    base_addr = b;
    rs = s + 1 + (inited_m ? 0 : 1);
    if (!inited_m) init_q.push_back(s + 1);
    inited_m = 1'b1;
    for (int k = 0; k < KE; k++) begin
      int a;
      a = (int'(b) + k) % DEPTH;
      addr_q.push_back('{cyc: rs + k, val: a, col: 0});
      for (int c = 0; c < COLS; c++)
        col_q.push_back('{cyc: rs + k + 2 + c, val: int'(rom[c][a]), col: c});
    end
    dc = rs + KE + COLS;
    done_q.push_back(dc);
    busy_from = s + 1;
    busy_to = dc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ADDR_DW'($urandom);
  endtask

  task automatic wait_until_idle(input int dc);
    while (cyc <= dc) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_one(input logic [ADDR_DW-1:0] b);
    int s, dc;
    apply_stimulus(b, s, dc);
    wait_until_idle(dc);
  endtask

  exp_t e;
  int   idx;
  logic exp_busy;

  always @(negedge clk) begin
    if (mon_en) begin
      if (initial_sig) begin
        if (init_q.size() == 0) flag_unexpected("initial_sig");
        else check_output("initial_sig cycle", cyc, init_q.pop_front());
      end
      if (RAenable) begin
        if (addr_q.size() == 0) flag_unexpected("RAenable");
        else begin
          e = addr_q.pop_front();
          check_output("read cycle", cyc, e.cyc);
          check_output("read addr", addr, e.val);
        end
      end else begin
        check_output("addr idle", addr, 0);
      end
      for (int c = 0; c < COLS; c++) begin
        if (w_valid[c]) begin
          idx = -1;
          for (int i = 0; i < col_q.size(); i++) begin
            if (col_q[i].col == c) begin
              idx = i;
              break;
            end
          end
          if (idx < 0) flag_unexpected("w_valid");
          else begin
            e = col_q[idx];
            col_q.delete(idx);
            check_output($sformatf("col%0d cycle", c), cyc, e.cyc);
            check_output($sformatf("col%0d data", c), w_out[c*DW +: DW], e.val);
          end
        end else begin
          check_output($sformatf("col%0d zero when invalid", c), w_out[c*DW +: DW], 0);
        end
      end
      if (done) begin
        if (done_q.size() == 0) flag_unexpected("done");
        else check_output("done cycle", cyc, done_q.pop_front());
      end
      exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
      check_output("busy", busy, exp_busy);
    end
  end

  initial begin
    int s, dc;
    for (int c = 0; c < COLS; c++)
      for (int a = 0; a < DEPTH; a++)
        rom[c][a] = DW'($urandom);
    rom[0][0]  = 8'hFE;
    rom[3][2]  = 8'h80;
    rom[7][24] = 8'hFF;
    rom[5][31] = 8'hFE;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset outputs",
                 {initial_sig, RAenable, addr, w_out, w_valid, busy, done}, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // First stream initialises the ROMs, later ones do not.
    run_one(5'd0);
    run_one(5'd5);
    run_one(5'd20);

    // Starts during READ and DRAIN must be ignored.
    apply_stimulus(ADDR_DW'($urandom), s, dc);
    repeat (4) @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_DW'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (24) @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_DW'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    wait_until_idle(dc);

    // Abort on READ k=10, then restart must re-initialise.
    apply_stimulus(ADDR_DW'($urandom), s, dc);
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    addr_q.delete();
    col_q.delete();
    init_q.delete();
    done_q.delete();
    busy_to = cyc - 1;
    inited_m = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_output("abort outputs",
                 {initial_sig, RAenable, addr, w_out, w_valid, busy, done}, 0);
    @(posedge clk); #1;
    run_one(ADDR_DW'($urandom));

    // Random bases with random idle gaps, including back-to-back starts.
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_one(ADDR_DW'($urandom));
    end
    run_one(5'd31);

    repeat (5) @(posedge clk); #1;
    check_output("leftover reads", addr_q.size(), 0);
    check_output("leftover words", col_q.size(), 0);
    check_output("leftover init", init_q.size(), 0);
    check_output("leftover done", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
